// File: rtl/ram_pkg.sv
// Shared constants, clear-FSM state type and byte parity helper for ram_param_sp.
package ram_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    // Even parity: stored bit makes the byte plus parity an even count of ones.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear sequencer: sweeps every word once, writing zero, while holding busy high.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) state_d = CLEAR;
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_addr = cnt_q;
endmodule

// File: rtl/ram_param_sp.sv
// Single-port byte-writable RAM with registered read and a whole-array clear sweep.
// Optional per-byte even parity storage when RAM_PARITY_EN is defined.
module ram_param_sp
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cs,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr_req,
    output logic                busy,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid
`ifdef RAM_PARITY_EN
    ,
    input  logic                err_inj,
    output logic                parity_err
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc_ok, wr_en, rd_en;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;

    ram_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request in the same cycle as an access wins; the access is dropped.
    assign acc_ok = cs & ~busy & ~clr_req;
    assign wr_en  = acc_ok & rw;
    assign rd_en  = acc_ok & ~rw;

    // Array is deliberately not reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[addr][8*i +: 8] <= data_in[8*i +: 8];
        end
    end

    assign data_out_d = rd_en ? mem[addr] : data_out_q;
    assign rd_valid_d = rd_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] rd_par;
    logic          parity_err_q, parity_err_d;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) par_mem[addr][i] <= byte_par(data_in[8*i +: 8]) ^ (err_inj && i == 0);
        end
    end

    always_comb begin
        rd_par = '0;
        for (int i = 0; i < NB; i++) rd_par[i] = byte_par(mem[addr][8*i +: 8]);
    end

    assign parity_err_d = rd_en & (|(rd_par ^ par_mem[addr]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_ram_param_sp.sv
// Directed + randomized bench for ram_param_sp against a word-array reference model.
module tb_ram_param_sp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0, reset_n = 1'b1, cs = 1'b0, rw = 1'b0, clr_req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [NB-1:0] be = '0;
    logic          busy, rd_valid;
    logic [DW-1:0] data_out;
`ifdef RAM_PARITY_EN
    logic          err_inj = 1'b0;
    logic          parity_err;
`endif

    int            checks = 0, errors = 0;
    logic [DW-1:0] model [DEPTH];

    ram_param_sp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .rw(rw), .addr(addr),
        .data_in(data_in), .be(be), .clr_req(clr_req), .busy(busy),
        .data_out(data_out), .rd_valid(rd_valid)
`ifdef RAM_PARITY_EN
        , .err_inj(err_inj), .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        cs = 1'b1; rw = 1'b1; addr = a; data_in = d; be = b;
        cycle();
        cs = 1'b0;
        for (int i = 0; i < NB; i++)
            if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        cs = 1'b1; rw = 1'b0; addr = a;
        cycle();
        cs = 1'b0;
        chk(tag, data_out, model[a]);
        chk({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
`ifdef RAM_PARITY_EN
        chk({tag, "_perr"}, {31'b0, parity_err}, 32'd0);
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] hold;
        // reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_dout", data_out, '0);
        chk("rst_vld", {31'b0, rd_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        cycle(); cycle();
        reset_n = 1'b1;
        cycle();

        for (int a = 0; a < DEPTH; a++) wr(AW'(a), $urandom, '1);

        // byte write merge
        wr(AW'(3), 32'hDEADBEEF, 4'b1111);
        wr(AW'(3), 32'h00001122, 4'b0011);
        chk("merge_model", model[3], 32'hDEAD1122);
        rd(AW'(3), "merge");
        hold = data_out;
        cycle();
        chk("vld_pulse", {31'b0, rd_valid}, 32'd0);
        chk("dout_hold", data_out, hold);

        // boundary addresses and be=0
        wr(AW'(0), $urandom, '1);
        wr(AW'(DEPTH-1), $urandom, '1);
        wr(AW'(DEPTH-1), $urandom, '0);
        rd(AW'(0), "addr_lo");
        rd(AW'(DEPTH-1), "addr_hi");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1)
                wr(AW'($urandom_range(0, DEPTH-1)), $urandom, NB'($urandom_range(0, 15)));
            else
                rd(AW'($urandom_range(0, DEPTH-1)), "rand_rd");
        end

        // clear sweep with writes attempted while busy
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'hFFFFFFFF, '1);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        n = 0;
        cs = 1'b1; rw = 1'b1; be = '1;
        while (busy && n < 100) begin
            addr = AW'($urandom_range(0, DEPTH-1));
            data_in = $urandom;
            cycle();
            n++;
        end
        cs = 1'b0;
        chk("busy_len", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        for (int a = 0; a < DEPTH; a++) rd(AW'(a), "clr_rd");

        // clear vs write collision
        wr(AW'(7), 32'h55AA55AA, '1);
        cs = 1'b1; rw = 1'b1; addr = AW'(7); data_in = 32'h12345678; be = '1; clr_req = 1'b1;
        cycle();
        cs = 1'b0; clr_req = 1'b0;
        chk("coll_busy", {31'b0, busy}, 32'd1);
        wait_idle("coll_idle");
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        rd(AW'(7), "coll_rd");

        // reset partway through a clear
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'hAAAAAAAA, '1);
        rd(AW'(20), "pre_rst_rd");
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (10) cycle();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_dout", data_out, '0);
        chk("arst_vld", {31'b0, rd_valid}, 32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        for (int a = 0; a < 10; a++) model[a] = '0;
        for (int a = 0; a < DEPTH; a++) rd(AW'(a), "abort_rd");

`ifdef RAM_PARITY_EN
        err_inj = 1'b1;
        wr(AW'(5), 32'h0F0F0F0F, '1);
        err_inj = 1'b0;
        cs = 1'b1; rw = 1'b0; addr = AW'(5);
        cycle();
        cs = 1'b0;
        chk("perr_inj", {31'b0, parity_err}, 32'd1);
        chk("perr_inj_vld", {31'b0, rd_valid}, 32'd1);
        chk("perr_inj_dat", data_out, 32'h0F0F0F0F);
        cycle();
        chk("perr_pulse", {31'b0, parity_err}, 32'd0);
        wr(AW'(5), 32'h0F0F0F0F, '1);
        rd(AW'(5), "perr_clean");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
